// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported byte memory between instruction fetch and load/store.
// Define MEMARB_RR_EN for round-robin arbitration; the default is fixed priority with LS winning ties.
module mem_port_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [2:0]    ls_func3,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_func3,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   owner_ls;
  logic   last_ls;
  logic   grant_ls;

  // Winner selection; only consulted in IDLE when at least one request is up.
  always_comb begin
    grant_ls = 1'b0;
`ifdef MEMARB_RR_EN
    grant_ls = ls_req & ~(if_req & last_ls);
`else
    grant_ls = ls_req;
`endif
  end

  // The mem_* registers double as the request latches: loaded at grant, cleared after ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_ls  <= 1'b0;
      last_ls   <= 1'b1;
      if_ack    <= 1'b0;
      ls_ack    <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_func3 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state     <= ACCESS;
            owner_ls  <= grant_ls;
            last_ls   <= grant_ls;
            mem_re    <= grant_ls ? ~ls_we : 1'b1;
            mem_we    <= grant_ls & ls_we;
            mem_addr  <= grant_ls ? ls_addr : if_addr;
            mem_wdata <= grant_ls ? ls_wdata : '0;
            mem_func3 <= grant_ls ? ls_func3 : 3'b010;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (!mem_we) begin
            if (owner_ls) ls_rdata <= mem_rdata;
            else          if_rdata <= mem_rdata;
          end
          if_ack    <= ~owner_ls;
          ls_ack    <= owner_ls;
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_func3 <= '0;
        end
        RESP: begin
          state  <= IDLE;
          if_ack <= 1'b0;
          ls_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
